// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared types and baud table for the UART receiver | rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  typedef struct packed {
    logic bit8;
    logic pen;
    logic ohel;
  } frame_cfg_t;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } fifo_entry_t;

  // Selects 12..15 alias the fastest rate.
  function automatic int unsigned baud_rate(input logic [3:0] sel);
    case (sel)
      4'd0:    return 300;
      4'd1:    return 1200;
      4'd2:    return 2400;
      4'd3:    return 4800;
      4'd4:    return 9600;
      4'd5:    return 19200;
      4'd6:    return 38400;
      4'd7:    return 57600;
      4'd8:    return 115200;
      4'd9:    return 230400;
      4'd10:   return 460800;
      default: return 921600;
    endcase
  endfunction

  function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [3:0] sel);
    return clk_hz / baud_rate(sel);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rx_fifo : synchronous show-ahead FIFO of receive entries | rev 1.0
// ---------------------------------------------------------------------------
module rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  fifo_entry_t            i_wdata,
  input  logic                   i_pop,
  output fifo_entry_t            o_rdata,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fifo_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  // A pop frees the slot a same-cycle push needs when full.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_fifo : UART receiver with parity/stop checks and buffered output | rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_in,
  input  logic [3:0]             baudm,
  input  logic                   bit8,
  input  logic                   pen,
  input  logic                   ohel,
  input  logic                   rd_en,
  input  logic                   clr_ovr,
  output logic [7:0]             rx_data,
  output logic                   rx_perr,
  output logic                   rx_ferr,
  output logic                   rx_valid,
  output logic                   rx_full,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   overrun
);

  localparam int unsigned CNT_W = $clog2(CLK_HZ / 300 + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev;
  logic                   w_rx;
  rx_state_t              r_state;
  rx_state_t              w_state_nx;
  frame_cfg_t             r_cfg;
  logic [3:0]             r_baud;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_bit;
  logic [7:0]             r_data;
  logic                   r_perr;
  logic                   r_ovr;
  logic [CNT_W-1:0]       w_div_idle;
  logic [CNT_W-1:0]       w_div;
  logic                   w_expire;
  logic                   w_last_bit;
  logic                   w_load_half;
  logic                   w_load_div;
  logic                   w_sample_data;
  logic                   w_sample_par;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_empty;
  logic                   w_full;
  fifo_entry_t            w_entry;
  fifo_entry_t            w_head;

  // Unrolls to a mux over elaboration-time constants, no divider.
  function automatic logic [CNT_W-1:0] div_of(input logic [3:0] sel);
    logic [CNT_W-1:0] d;
    d = '0;
    for (int k = 0; k < 16; k++)
      if (sel == 4'(k)) d = CNT_W'(baud_div(CLK_HZ, 4'(k)));
    return d;
  endfunction

  assign w_div_idle = div_of(baudm);
  assign w_div      = div_of(r_baud);
  assign w_rx       = r_sync[SYNC_STAGES-1];
  assign w_expire   = (r_cnt == '0);
  assign w_last_bit = (r_bit == (r_cfg.bit8 ? 3'd7 : 3'd6));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], rx_in};
      r_rx_prev <= w_rx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // Start needs a 1->0 edge, so a held-low break never retriggers.
  always_comb begin
    w_state_nx    = r_state;
    w_load_half   = 1'b0;
    w_load_div    = 1'b0;
    w_sample_data = 1'b0;
    w_sample_par  = 1'b0;
    w_push        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_rx_prev && !w_rx) begin
          w_load_half = 1'b1;
          w_state_nx  = ST_START;
        end
      end
      ST_START: begin
        if (w_expire) begin
          if (w_rx) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_load_div = 1'b1;
            w_state_nx = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_expire) begin
          w_sample_data = 1'b1;
          w_load_div    = 1'b1;
          if (w_last_bit) w_state_nx = r_cfg.pen ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_expire) begin
          w_sample_par = 1'b1;
          w_load_div   = 1'b1;
          w_state_nx   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_expire) begin
          w_push     = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_cfg  <= '0;
      r_baud <= '0;
      r_bit  <= '0;
      r_data <= '0;
      r_perr <= 1'b0;
    end else begin
      if (w_load_half)     r_cnt <= (w_div_idle >> 1) - 1'b1;
      else if (w_load_div) r_cnt <= w_div - 1'b1;
      else if (!w_expire)  r_cnt <= r_cnt - 1'b1;

      if (w_load_half) begin
        r_cfg  <= '{bit8: bit8, pen: pen, ohel: ohel};
        r_baud <= baudm;
        r_bit  <= '0;
        r_data <= '0;
        r_perr <= 1'b0;
      end
      if (w_sample_data) begin
        r_data[r_bit] <= w_rx;
        r_bit         <= r_bit + 1'b1;
      end
      if (w_sample_par) r_perr <= w_rx ^ (^r_data) ^ r_cfg.ohel;
    end
  end

  assign w_entry = '{ferr: ~w_rx, perr: r_perr, data: r_data};
  assign w_drop  = w_push && w_full && !rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_ovr <= 1'b0;
    else if (w_drop)  r_ovr <= 1'b1;
    else if (clr_ovr) r_ovr <= 1'b0;
  end

  rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_pop   (rd_en),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (rx_count)
  );

  assign rx_data  = w_head.data;
  assign rx_perr  = w_head.perr;
  assign rx_ferr  = w_head.ferr;
  assign rx_valid = !w_empty;
  assign rx_full  = w_full;
  assign overrun  = r_ovr;

endmodule
`default_nettype wire
